// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame packer.
// Frame geometry, default sync byte, one-hot serializer states.
package adc_pkg;

   localparam int NUM_CH      = 8;
   localparam int SAMPLE_W    = 16;
   localparam int FRAME_W     = NUM_CH * SAMPLE_W;
   localparam int FRAME_BYTES = 19;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_SYNC = 5'b00010,
      S_SEQ  = 5'b00100,
      S_DATA = 5'b01000,
      S_CSUM = 5'b10000
   } ser_state_e;

   // Even idx is the high byte of channel idx/2, odd idx the low byte.
   function automatic logic [7:0] frame_byte(
      input logic [FRAME_W-1:0] frame,
      input logic [3:0]         idx
   );
      logic [SAMPLE_W-1:0] s;
      s = frame[{idx[3:1], 4'b0000} +: SAMPLE_W];
      return idx[0] ? s[7:0] : s[15:8];
   endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Frame input and packet byte stream of the ADC frame packer.
// master drives frames and tx_ready; slave is the packer.
interface adc_frame_packer_if
   import adc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OVF_W      = 16
) ();

   logic [FRAME_W-1:0]            data;
   logic                          data_valid;
   logic [7:0]                    tx_data;
   logic                          tx_valid;
   logic                          tx_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic [OVF_W-1:0]              overflow_cnt;

   modport master (
      output data, data_valid, tx_ready,
      input  tx_data, tx_valid, fifo_level, overflow_cnt
   );

   modport slave (
      input  data, data_valid, tx_ready,
      output tx_data, tx_valid, fifo_level, overflow_cnt
   );

endinterface

// File: rtl/adc_frame_fifo.sv
// Synchronous frame FIFO with wrap-bit pointers.
// Head entry is read combinationally.
module adc_frame_fifo
   import adc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = FRAME_W + 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;

   always_comb begin
      level = wr_q - rd_q;
      full  = (level == (AW+1)'(DEPTH));
      empty = (wr_q == rd_q);
      dout  = mem_q[rd_q[AW-1:0]];
      wr_d  = (push && !full) ? wr_q + 1'b1 : wr_q;
      rd_d  = (pop && !empty) ? rd_q + 1'b1 : rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/adc_frame_packer.sv
// Buffers ADC frames and serializes each into a 19-byte packet:
// sync, seq, 16 sample bytes, XOR checksum of bytes 1..17.
module adc_frame_packer
   import adc_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int         OVF_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   adc_frame_packer_if.slave  bus
);

   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = FRAME_W + 8;

   logic [7:0]       seq_q, seq_d;
   logic [OVF_W-1:0] ovf_q, ovf_d;
   ser_state_e       state_q, state_d;
   logic [3:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       csum_q, csum_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;

   logic               push, pop, hs;
   logic [7:0]         csum_nx;
   logic [ENTRY_W-1:0] head;
   logic [LVL_W-1:0]   level;
   logic               full, empty;

   adc_frame_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   ({seq_q, bus.data}),
      .dout  (head),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      push    = bus.data_valid && !full;
      hs      = tx_valid_q && bus.tx_ready;
      csum_nx = csum_q ^ tx_data_q;
      seq_d   = bus.data_valid ? seq_q + 8'd1 : seq_q;
      ovf_d   = ovf_q;
      if (bus.data_valid && full && !(&ovf_q))
         ovf_d = ovf_q + OVF_W'(1);
      pop        = 1'b0;
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      csum_d     = csum_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      unique case (state_q)
         S_IDLE: if (!empty) begin
            state_d    = S_SYNC;
            tx_valid_d = 1'b1;
            tx_data_d  = SYNC_BYTE;
         end
         S_SYNC: if (hs) begin
            state_d   = S_SEQ;
            csum_d    = 8'h00;
            tx_data_d = head[ENTRY_W-1 -: 8];
         end
         S_SEQ: if (hs) begin
            state_d    = S_DATA;
            csum_d     = csum_nx;
            byte_idx_d = 4'd0;
            tx_data_d  = frame_byte(head[FRAME_W-1:0], 4'd0);
         end
         S_DATA: if (hs) begin
            csum_d = csum_nx;
            if (byte_idx_q == 4'd15) begin
               state_d   = S_CSUM;
               tx_data_d = csum_nx;
            end else begin
               byte_idx_d = byte_idx_q + 4'd1;
               tx_data_d  = frame_byte(head[FRAME_W-1:0],
                                       byte_idx_q + 4'd1);
            end
         end
         S_CSUM: if (hs) begin
            pop = 1'b1;
            // A same-cycle push keeps a frame queued after this pop.
            if (level > LVL_W'(1) || push) begin
               state_d   = S_SYNC;
               tx_data_d = SYNC_BYTE;
            end else begin
               state_d    = S_IDLE;
               tx_valid_d = 1'b0;
               tx_data_d  = 8'h00;
            end
         end
         default: begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q      <= '0;
         ovf_q      <= '0;
         state_q    <= S_IDLE;
         byte_idx_q <= '0;
         csum_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         seq_q      <= seq_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         csum_q     <= csum_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.tx_data      = tx_data_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.fifo_level   = level;
   assign bus.overflow_cnt = ovf_q;

endmodule
